// File: rtl/pitch_gen_pkg.sv
// pitch_gen_pkg: shared state encoding, bus word field positions and note record for pitch_gen, software and bench
package pitch_gen_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, PLAY = 2'd2} state_t;
  localparam int FLUSH_BIT = 31;
  localparam int DUR_MSB = 30;
  localparam int DUR_LSB = 16;
  localparam int HALF_MSB = 15;
  localparam int HALF_LSB = 0;
  localparam int NOTE_W = 36;
  typedef struct packed {
    logic [19:0] dur;
    logic [15:0] half;
  } note_t;
  function automatic note_t decode_note(input logic [31:0] w);
    return {5'b0, w[DUR_MSB:DUR_LSB], w[HALF_MSB:HALF_LSB]};
  endfunction
endpackage

// File: rtl/note_fifo.sv
// note_fifo: note queue (clk, rst async; push/pop/clr sync; din/dout note_t; count/full/empty status); a push while full only lands if a pop frees a slot in the same cycle
module note_fifo
  import pitch_gen_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       clr,
  input  note_t      din,
  output note_t      dout,
  output logic [3:0] count,
  output logic       full,
  output logic       empty
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  note_t mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic do_push, do_pop;
  assign full = count == 4'(DEPTH);
  assign empty = count == 4'd0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rd];
  always_ff @(posedge clk)
    if (do_push && !clr) mem[wr] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else if (clr) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      rd <= do_pop ? (rd == AW'(DEPTH - 1) ? '0 : rd + 1'b1) : rd;
      wr <= do_push ? (wr == AW'(DEPTH - 1) ? '0 : wr + 1'b1) : wr;
      count <= count + {3'b0, do_push} - {3'b0, do_pop};
    end
endmodule

// File: rtl/pitch_gen.sv
// pitch_gen: queued square-wave note player (clk, rst async; pitch_gen_we/pitch_gen_out bus write; pitch_gen_in status; buzzer audio; playing)
module pitch_gen
  import pitch_gen_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pitch_gen_we,
  input  logic [31:0] pitch_gen_out,
  output logic [31:0] pitch_gen_in,
  output logic        buzzer,
  output logic        playing
);
  localparam int DIV = CLK_HZ / 1_000_000;
  localparam int UW = DIV > 1 ? $clog2(DIV) : 1;
  state_t state, state_n;
  note_t cur, head;
  logic [UW-1:0] us_cnt;
  logic [9:0] ms_cnt;
  logic [15:0] half_cnt;
  logic [19:0] dur_cnt;
  logic [3:0] count;
  logic full, empty, overflow;
  logic flush, push, pop, avail, run, us_tick, ms_tick, half_hit, dur_hit;
  assign flush = pitch_gen_we && pitch_gen_out[FLUSH_BIT];
  assign push = pitch_gen_we && !pitch_gen_out[FLUSH_BIT];
  assign pop = state == LOAD;
  // a note being written this cycle counts as available so IDLE reaches LOAD one cycle later
  assign avail = !empty || push;
  assign playing = state == PLAY;
  assign us_tick = playing && us_cnt == UW'(DIV - 1);
  assign ms_tick = us_tick && ms_cnt == 10'd999;
  assign half_hit = us_tick && cur.half != 16'd0 && half_cnt == cur.half - 16'd1;
  assign dur_hit = ms_tick && cur.dur != 20'd0 && dur_cnt == cur.dur - 20'd1;
  assign run = playing && state_n == PLAY;
  note_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .clr  (flush),
    .din  (decode_note(pitch_gen_out)),
    .dout (head),
    .count(count),
    .full (full),
    .empty(empty)
  );
  always_comb begin
    state_n = state;
    if (flush) state_n = IDLE;
    else if (state == IDLE) state_n = avail ? LOAD : IDLE;
    else if (state == LOAD) state_n = PLAY;
    else if (dur_hit || (cur.dur == 20'd0 && avail)) state_n = avail ? LOAD : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cur <= '0;
      us_cnt <= '0;
      ms_cnt <= '0;
      half_cnt <= '0;
      dur_cnt <= '0;
      buzzer <= 1'b0;
      overflow <= 1'b0;
      pitch_gen_in <= '0;
    end else begin
      state <= state_n;
      pitch_gen_in <= {overflow, playing, 26'b0, count};
      overflow <= !flush && (overflow || (push && full && !pop));
      cur <= pop ? head : cur;
      // counters restart on PLAY entry and buzzer falls on any exit
      us_cnt <= run && !us_tick ? us_cnt + 1'b1 : '0;
      ms_cnt <= run ? (ms_tick ? 10'd0 : ms_cnt + {9'b0, us_tick}) : 10'd0;
      half_cnt <= run ? (half_hit ? 16'd0 : half_cnt + {15'b0, us_tick}) : 16'd0;
      dur_cnt <= run ? dur_cnt + {19'b0, ms_tick} : 20'd0;
      buzzer <= run && (buzzer ^ half_hit);
    end
endmodule

// File: tb/tb_pitch_gen.sv
// tb_pitch_gen: directed self-checking bench for pitch_gen at CLK_HZ=4 MHz (one us = 4 cycles)
module tb_pitch_gen;
  import pitch_gen_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pitch_gen_we = 1'b0;
  logic [31:0] pitch_gen_out = '0;
  logic [31:0] pitch_gen_in;
  logic buzzer, playing;
  int vectors = 0;
  int misses = 0;
  localparam logic [31:0] FLUSH = 32'h8000_0000;

  pitch_gen #(.CLK_HZ(4_000_000), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .pitch_gen_we (pitch_gen_we),
    .pitch_gen_out(pitch_gen_out),
    .pitch_gen_in (pitch_gen_in),
    .buzzer       (buzzer),
    .playing      (playing)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] note(input int dur, input int half);
    logic [14:0] d;
    logic [15:0] h;
    d = 15'(dur);
    h = 16'(half);
    return {1'b0, d, h};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] data);
    pitch_gen_we = 1'b1;
    pitch_gen_out = data;
    tick(1);
    pitch_gen_we = 1'b0;
    pitch_gen_out = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      misses++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    pitch_gen_we = 1'b1;
    pitch_gen_out = note(1, 5);
    tick(3);
    pitch_gen_we = 1'b0;
    chk("rst_playing", 32'(playing), 0);
    chk("rst_buzzer", 32'(buzzer), 0);
    chk("rst_status", pitch_gen_in, 0);
    rst = 1'b0;
    tick(3);
    chk("rst_write_ignored", 32'(playing), 0);
    chk("rst_write_status", pitch_gen_in, 0);
    pitch_gen_out = note(1, 5);
    tick(3);
    chk("we_low_ignored", 32'(playing), 0);
    chk("we_low_status", pitch_gen_in, 0);
    pitch_gen_out = '0;

    wr(note(2, 250));
    chk("single_load", 32'(playing), 0);
    tick(1);
    chk("single_play_entry", 32'(playing), 1);
    chk("single_buzzer_entry", 32'(buzzer), 0);
    for (int k = 1; k <= 8; k++) begin
      tick(999);
      chk($sformatf("single_hold_%0d", k), 32'(buzzer), 32'((k - 1) % 2));
      tick(1);
      chk($sformatf("single_toggle_%0d", k), 32'(buzzer), 32'(k % 2));
    end
    chk("single_end_idle", 32'(playing), 0);
    tick(1);
    chk("single_status_idle", pitch_gen_in, 0);

    for (int i = 0; i < 5; i++) wr(note(1, 0));
    tick(1);
    chk("ovf_none_dropped", pitch_gen_in, 32'h4000_0004);
    wr(note(1, 0));
    tick(1);
    chk("ovf_sticky", pitch_gen_in, 32'hC000_0004);
    wr(FLUSH);
    chk("ovf_flush_idle", 32'(playing), 0);
    chk("ovf_flush_buzzer", 32'(buzzer), 0);
    tick(1);
    chk("ovf_flush_status", pitch_gen_in, 0);

    wr(note(1, 0));
    wr(note(1, 0));
    chk("b2b_first_play", 32'(playing), 1);
    tick(3999);
    chk("b2b_first_late", 32'(playing), 1);
    tick(1);
    chk("b2b_load_gap", 32'(playing), 0);
    tick(1);
    chk("b2b_second_play", 32'(playing), 1);
    chk("b2b_rest_buzzer", 32'(buzzer), 0);
    tick(3999);
    chk("b2b_second_late", 32'(playing), 1);
    tick(1);
    chk("b2b_idle", 32'(playing), 0);
    tick(1);
    chk("b2b_stay_idle", 32'(playing), 0);

    wr(note(0, 10));
    tick(1);
    chk("sus_play", 32'(playing), 1);
    for (int k = 0; k < 20; k++) begin
      tick(1000);
      chk($sformatf("sus_run_%0d", k), 32'(playing), 1);
    end
    chk("sus_buzzer_even", 32'(buzzer), 0);
    tick(40);
    chk("sus_buzzer_odd", 32'(buzzer), 1);
    wr(note(1, 1));
    chk("sus_to_load", 32'(playing), 0);
    tick(1);
    chk("mid_play", 32'(playing), 1);
    wr(note(1, 0));
    wr(note(1, 0));
    wr(note(1, 0));
    chk("mid_buzzer_low", 32'(buzzer), 0);
    tick(1);
    chk("mid_buzzer_high", 32'(buzzer), 1);
    chk("mid_queued3", pitch_gen_in, 32'h4000_0003);
    wr(FLUSH);
    chk("mid_flush_idle", 32'(playing), 0);
    chk("mid_flush_buzzer", 32'(buzzer), 0);
    tick(1);
    chk("mid_flush_status", pitch_gen_in, 0);

    wr(note(2, 1));
    tick(1);
    chk("arst_play", 32'(playing), 1);
    tick(4);
    chk("arst_buzzer_high", 32'(buzzer), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_buzzer", 32'(buzzer), 0);
    chk("arst_playing", 32'(playing), 0);
    chk("arst_status", pitch_gen_in, 0);
    tick(1);
    rst = 1'b0;
    tick(2);
    chk("arst_idle", 32'(playing), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end
endmodule
